// File: rtl/ones_pattern_gen_pkg.sv
// Shared types and helpers for the same-popcount word enumerator.
package ones_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int DEFAULT_W = 8;

  // Binomial coefficient C(n, r); zero outside 0..n.
  function automatic int binom(input int n, input int r);
    int acc;
    if (r < 0 || r > n) return 0;
    acc = 1;
    for (int i = 1; i <= r; i++) acc = acc * (n - r + i) / i;
    return acc;
  endfunction

endpackage

// File: rtl/popcount_w.sv
// Parameterized combinational ones-counter.
module popcount_w #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) count_o = count_o + CW'(data_i[i]);
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every W-bit word with exactly k ones, ascending, over a valid/ready port.
// Optional self-check (popcount + monotonicity) enabled by ONES_PATTERN_GEN_CHECK_EN.
module ones_pattern_gen
  import ones_pattern_gen_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(W + 1),
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] k,
  output logic          busy,
  output logic          pat_valid,
  input  logic          pat_ready,
  output logic [W-1:0]  pat,
  output logic [IW-1:0] pat_idx,
  output logic          pat_last,
  output logic          done,
  output logic          err,
  output state_e        dbg_state
`ifdef ONES_PATTERN_GEN_CHECK_EN
  ,
  output logic          chk_err
`endif
);

  // Handshake: a word transfers on a rising edge where pat_valid & pat_ready;
  // pat/pat_idx/pat_last are held stable while pat_valid & !pat_ready.

  state_e        state_q;
  logic          busy_q, valid_q, last_q, done_q, err_q;
  logic [W-1:0]  pat_q, last_pat_q;
  logic [IW-1:0] idx_q;

  logic          k_ill;
  logic [W-1:0]  first_pat, final_pat, nxt;
  logic [W:0]    p_ext, c_ext, r_ext, t_ext;
  logic [CW-1:0] sh;

  function automatic logic [CW-1:0] ctz(input logic [W:0] v);
    logic [CW-1:0] res;
    res = '0;
    for (int i = W; i >= 0; i--) if (v[i]) res = CW'(i);
    return res;
  endfunction

  assign k_ill = (k > CW'(W));

  always_comb begin
    first_pat = '0;
    final_pat = '0;
    for (int i = 0; i < W; i++) begin
      first_pat[i] = (i < int'(k));
      final_pat[i] = (i >= W - int'(k));
    end
  end

  // Same-popcount successor; the shift by ctz(c) stands in for division by c.
  always_comb begin
    p_ext = {1'b0, pat_q};
    c_ext = p_ext & (~p_ext + {{W{1'b0}}, 1'b1});
    r_ext = p_ext + c_ext;
    sh    = ctz(c_ext);
    t_ext = ((r_ext ^ p_ext) >> 2) >> sh;
    nxt   = W'(r_ext | t_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pat_q      <= '0;
      last_pat_q <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q  <= k_ill;
            busy_q <= 1'b1;
            if (k_ill) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              valid_q    <= 1'b1;
              pat_q      <= first_pat;
              last_pat_q <= final_pat;
              idx_q      <= '0;
              last_q     <= (first_pat == final_pat);
            end
          end
        end
        ST_RUN: begin
          if (pat_ready) begin
            if (last_q) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pat_q  <= nxt;
              idx_q  <= idx_q + IW'(1);
              last_q <= (nxt == last_pat_q);
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign pat_valid = valid_q;
  assign pat       = pat_q;
  assign pat_idx   = idx_q;
  assign pat_last  = last_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

`ifdef ONES_PATTERN_GEN_CHECK_EN
  logic [CW-1:0] k_q, pc;
  logic          chk_err_q;

  popcount_w #(.W(W), .CW(CW)) u_popcount (
    .data_i  (pat_q),
    .count_o (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q       <= '0;
      chk_err_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      k_q       <= k;
      chk_err_q <= 1'b0;
    end else if (state_q == ST_RUN && pat_ready) begin
      if (pc != k_q) chk_err_q <= 1'b1;
      if (!last_q && nxt <= pat_q) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule
